vec_store_sequencer: RTL and testbench
======================================

Name: vec_store_sequencer

Overview:
Schedules the single data-memory write port between the core's scalar store path and 5-lane vector stores.
- Captures all vector lanes when a vector store is issued.
- Stalls the single-cycle core (PC hold) and emits one word write per cycle at consecutive word addresses.
- Releases the stall for exactly one retire cycle.
- Sits between the arm core outputs (MemWrite, ALUResult, WriteData, VecWriteData_0..4) and data memory.

Parameters:
LANES, 5, number of vector lanes captured and written per burst
DATA_W, 32, lane / word width in bits
WORD_BYTES, 4, byte address increment between lanes

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
vec_store  in  1  core is executing a vector store (level, held while stalled)
vec_mask  in  LANES  per-lane write enable for the burst; bit i = lane i
scalar_we  in  1  core MemWrite
scalar_addr  in  DATA_W  core ALUResult (scalar address / vector base)
scalar_wdata  in  DATA_W  core WriteData
vec_data  in  LANES*DATA_W  lane i at bits [i*DATA_W +: DATA_W] (VecWriteData_i)
stall  out  1  freeze PC / register writes of core
mem_we  out  1  data-memory write enable
mem_addr  out  DATA_W  data-memory address
mem_wdata  out  DATA_W  data-memory write data
busy  out  1  state != IDLE
done  out  1  one-cycle pulse in the retire cycle

Behaviour:
- States: IDLE, BURST, RETIRE. A lane index register counts 0..LANES-1. Capture registers hold base, mask and lanes.
- IDLE:
  - mem_* pass scalar_* through combinationally (mem_we = scalar_we).
  - stall = vec_store (combinational), so the core does not advance in the issue cycle.
  - If vec_store = 1: on the edge, capture base = scalar_addr with bits[1:0] forced to 0, plus vec_mask and vec_data. Set lane = 0 and go to BURST. Scalar write is suppressed (mem_we = 0) in the issue cycle.
- BURST:
  - stall = 1.
  - mem_we = mask[lane]; mem_addr = base + WORD_BYTES*lane (mod 2^DATA_W, wraps silently); mem_wdata = lane data.
  - scalar_* ignored.
  - lane increments each cycle. At lane = LANES-1, go to RETIRE.
  - Masked lanes still take one cycle, so latency is fixed.
- RETIRE:
  - stall = 0, done = 1, mem_we = 0.
  - vec_store is ignored (the same instruction retires this cycle).
  - Next state is IDLE unconditionally.
- Latency: issue cycle + LANES burst cycles + 1 retire cycle = 7 cycles for LANES = 5. First memory write occurs 1 cycle after issue.
- Back-to-back vector stores: a new vec_store sampled in IDLE the cycle after RETIRE starts a new burst. There is no bubble beyond IDLE's issue cycle.
- vec_data or vec_mask changing during BURST has no effect; captured values are used.
- Reset:
  - reset = 1 forces state IDLE and lane 0 on the edge.
  - While reset is high, all outputs are 0 (stall, mem_we, busy, done, mem_addr, mem_wdata).
  - Reset mid-burst aborts the burst with no further writes. Captured registers clear to 0.
- All-zero mask: burst still runs 5 cycles with mem_we = 0 throughout; done still pulses.

Decomposition:
- Shared package `vec_pkg`:
  - state enum {IDLE, BURST, RETIRE}
  - LANES = 5, DATA_W = 32, WORD_BYTES = 4
  - lane-index width = $clog2(LANES)
  - the arm top and datapath vector lanes reference the same constants.
- One sub-module is natural: `vec_lane_mux`, which selects the captured lane word and mask bit from the lane index (combinational, parameterised by LANES/DATA_W).
- FSM, counter and capture registers stay in the top.

Test Plan:
- Scalar pass-through: IDLE, scalar_we=1, addr=0x40, wdata=0xDEADBEEF, vec_store=0 -> same cycle mem_we=1, addr 0x40, data 0xDEADBEEF, stall=0.
- Full burst: vec_store=1, base=0x100, mask=5'b11111, lanes 0x11,0x22,0x33,0x44,0x55 -> stall high 6 cycles; writes 0x100..0x110 step 4 with those data; RETIRE cycle stall=0, done=1; IDLE after.
- Mask and alignment: base=0x203, mask=5'b10101 -> writes only 0x200, 0x208, 0x210; cycles for lanes 1 and 3 have mem_we=0; total latency still 7.
- Wrap-around: base=0xFFFFFFF8, all lanes enabled -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4, 0x8.
- Reset mid-burst: assert reset at lane 2 -> next cycle state IDLE, all outputs 0, no writes to lanes 3 or 4, no done pulse.
- Back-to-back and scalar blocking: second vec_store right after RETIRE starts a new burst. A scalar_we=1 driven during BURST never appears on mem_we.

Source files
------------

// File: rtl/vec_pkg.sv
// Shared constants and types for the vector store sequencer and the
// vector lanes of the core datapath.
package vec_pkg;

  localparam int LANES      = 5;
  localparam int DATA_W     = 32;
  localparam int WORD_BYTES = 4;
  localparam int LANE_W     = $clog2(LANES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BURST  = 2'd1,
    RETIRE = 2'd2
  } vec_state_e;

  // Clear the byte-offset bits so every lane lands on a word boundary.
  function automatic logic [DATA_W-1:0] align_word(input logic [DATA_W-1:0] addr);
    return {addr[DATA_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/vec_lane_mux.sv
// Selects one captured lane word and its write-enable bit by lane index.
module vec_lane_mux #(
  parameter int LANES  = 5,
  parameter int DATA_W = 32,
  parameter int LANE_W = $clog2(LANES)
) (
  input  logic [LANES*DATA_W-1:0] lanes_i,
  input  logic [LANES-1:0]        mask_i,
  input  logic [LANE_W-1:0]       idx_i,
  output logic [DATA_W-1:0]       word_o,
  output logic                    en_o
);

  // One-of-LANES select; an out-of-range index yields a disabled zero word.
  always_comb begin
    word_o = '0;
    en_o   = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      word_o = (idx_i == LANE_W'(i)) ? lanes_i[i*DATA_W +: DATA_W] : word_o;
      en_o   = (idx_i == LANE_W'(i)) ? mask_i[i] : en_o;
    end
  end

endmodule

// File: rtl/vec_store_sequencer.sv
// Arbitrates the single data-memory write port between scalar stores and
// fixed-latency vector store bursts, stalling the core during a burst.
module vec_store_sequencer
  import vec_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    vec_store,
  input  logic [LANES-1:0]        vec_mask,
  input  logic                    scalar_we,
  input  logic [DATA_W-1:0]       scalar_addr,
  input  logic [DATA_W-1:0]       scalar_wdata,
  input  logic [LANES*DATA_W-1:0] vec_data,
  output logic                    stall,
  output logic                    mem_we,
  output logic [DATA_W-1:0]       mem_addr,
  output logic [DATA_W-1:0]       mem_wdata,
  output logic                    busy,
  output logic                    done
);

  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

  vec_state_e                state_q;
  logic [LANE_W-1:0]         lane_q;
  logic [DATA_W-1:0]         base_q;
  logic [LANES-1:0]          mask_q;
  logic [LANES*DATA_W-1:0]   data_q;

  logic [DATA_W-1:0]         lane_word;
  logic                      lane_en;
  logic [DATA_W-1:0]         lane_offset;

  vec_lane_mux #(
    .LANES  (LANES),
    .DATA_W (DATA_W),
    .LANE_W (LANE_W)
  ) u_lane_mux (
    .lanes_i (data_q),
    .mask_i  (mask_q),
    .idx_i   (lane_q),
    .word_o  (lane_word),
    .en_o    (lane_en)
  );

  assign lane_offset = DATA_W'(WORD_BYTES) * DATA_W'(lane_q);

  // Burst FSM: capture on issue, walk every lane once, then one retire cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      lane_q  <= '0;
      base_q  <= '0;
      mask_q  <= '0;
      data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (vec_store) begin
            base_q  <= align_word(scalar_addr);
            mask_q  <= vec_mask;
            data_q  <= vec_data;
            lane_q  <= '0;
            state_q <= BURST;
          end else begin
            state_q <= IDLE;
          end
        end
        BURST: begin
          // Masked lanes still consume their cycle so latency never varies.
          if (lane_q == LAST_LANE) begin
            lane_q  <= '0;
            state_q <= RETIRE;
          end else begin
            lane_q  <= lane_q + LANE_W'(1);
          end
        end
        RETIRE: begin
          // The vector store retires now; a held vec_store is not a new issue.
          state_q <= IDLE;
        end
        default: begin
          lane_q  <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Port steering: scalar pass-through in IDLE, captured lanes in BURST.
  always_comb begin
    stall     = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    busy      = 1'b0;
    done      = 1'b0;
    if (reset) begin
      stall = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          stall     = vec_store;
          mem_we    = scalar_we & ~vec_store;
          mem_addr  = scalar_addr;
          mem_wdata = scalar_wdata;
        end
        BURST: begin
          stall     = 1'b1;
          busy      = 1'b1;
          mem_we    = lane_en;
          mem_addr  = base_q + lane_offset;
          mem_wdata = lane_word;
        end
        RETIRE: begin
          busy = 1'b1;
          done = 1'b1;
        end
        default: begin
          busy = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vec_store_sequencer.sv
// Randomised scoreboard bench for vec_store_sequencer.
module tb_vec_store_sequencer;
  import vec_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic         vec_store;
  logic [4:0]   vec_mask;
  logic         scalar_we;
  logic [31:0]  scalar_addr;
  logic [31:0]  scalar_wdata;
  logic [159:0] vec_data;
  logic         stall, mem_we, busy, done;
  logic [31:0]  mem_addr, mem_wdata;

  always #5 clk = ~clk;

  vec_store_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .vec_store    (vec_store),
    .vec_mask     (vec_mask),
    .scalar_we    (scalar_we),
    .scalar_addr  (scalar_addr),
    .scalar_wdata (scalar_wdata),
    .vec_data     (vec_data),
    .stall        (stall),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .busy         (busy),
    .done         (done)
  );

  typedef struct packed {
    logic        stall;
    logic        we;
    logic        busy;
    logic        done;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obs_t;

  obs_t  exp_q[$];
  string name_q[$];
  int    errors = 0;
  int    checks = 0;

  task automatic expect_cyc(input string nm, input logic st, input logic we, input logic bs,
                            input logic dn, input logic [31:0] ad, input logic [31:0] wd);
    obs_t e;
    e.stall = st; e.we = we; e.busy = bs; e.done = dn; e.addr = ad; e.wdata = wd;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic scramble_side_inputs();
    vec_mask     = 5'($urandom);
    vec_data     = {$urandom, $urandom, $urandom, $urandom, $urandom};
    scalar_addr  = $urandom;
    scalar_wdata = $urandom;
  endtask

  // One IDLE cycle carrying a scalar access: the memory port mirrors it.
  task automatic drive_scalar(input logic we, input logic [31:0] addr, input logic [31:0] data,
                              input string nm);
    @(posedge clk); #1;
    scramble_side_inputs();
    reset = 1'b0; vec_store = 1'b0;
    scalar_we = we; scalar_addr = addr; scalar_wdata = data;
    expect_cyc(nm, 1'b0, we, 1'b0, 1'b0, addr, data);
  endtask

  // A full vector store instruction; abort_at >= 0 pulses reset on that lane cycle.
  task automatic drive_vec(input logic [31:0] base, input logic [4:0] mask,
                           input logic [159:0] lanes, input int abort_at, input string nm);
    logic [31:0] aligned;
    aligned = base & 32'hFFFF_FFFC;
    @(posedge clk); #1;
    reset = 1'b0; vec_store = 1'b1;
    scalar_we = 1'($urandom); scalar_addr = base; scalar_wdata = $urandom;
    vec_mask = mask; vec_data = lanes;
    expect_cyc($sformatf("%s/issue", nm), 1'b1, 1'b0, 1'b0, 1'b0, base, scalar_wdata);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      scramble_side_inputs();
      scalar_we = 1'b1;
      if (i == abort_at) begin
        reset = 1'b1;
        expect_cyc($sformatf("%s/reset_lane%0d", nm, i), 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0; vec_store = 1'b0; scalar_we = 1'b0;
        scalar_addr = 32'h0; scalar_wdata = 32'h0;
        expect_cyc($sformatf("%s/after_reset", nm), 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        return;
      end
      expect_cyc($sformatf("%s/lane%0d", nm, i), 1'b1, mask[i], 1'b1, 1'b0,
                 aligned + 32'(4 * i), lanes[i*32 +: 32]);
    end
    @(posedge clk); #1;
    scramble_side_inputs();
    scalar_we = 1'b1;
    expect_cyc($sformatf("%s/retire", nm), 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0);
  endtask

  // Monitor: compare whatever the DUT shows mid-cycle against the oldest expectation.
  always @(negedge clk) begin
    obs_t  e;
    obs_t  a;
    string nm;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = {stall, mem_we, busy, done, mem_addr, mem_wdata};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got stall=%b we=%b busy=%b done=%b addr=%h wdata=%h, want stall=%b we=%b busy=%b done=%b addr=%h wdata=%h",
                 nm, a.stall, a.we, a.busy, a.done, a.addr, a.wdata,
                 e.stall, e.we, e.busy, e.done, e.addr, e.wdata);
      end
    end
  end

  initial begin
    logic [159:0] lanes;
    int           r;
    reset = 1'b1; vec_store = 1'b0; scalar_we = 1'b0;
    vec_mask = 5'h0; vec_data = 160'h0; scalar_addr = 32'h0; scalar_wdata = 32'h0;

    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      scramble_side_inputs();
      reset = 1'b1; vec_store = 1'b1; scalar_we = 1'b1;
      expect_cyc("reset_outputs", 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    end

    drive_scalar(1'b1, 32'h40, 32'hDEAD_BEEF, "scalar_pass");
    drive_scalar(1'b0, 32'h44, 32'h1234_5678, "scalar_idle");

    lanes = {32'h55, 32'h44, 32'h33, 32'h22, 32'h11};
    drive_vec(32'h100, 5'b11111, lanes, -1, "full_burst");
    drive_scalar(1'b0, 32'h0, 32'h0, "idle_after_full");

    lanes = {32'hE4, 32'hD3, 32'hC2, 32'hB1, 32'hA0};
    drive_vec(32'h203, 5'b10101, lanes, -1, "mask_align");

    lanes = {$urandom, $urandom, $urandom, $urandom, $urandom};
    drive_vec(32'hFFFF_FFF8, 5'b11111, lanes, -1, "wrap");

    lanes = {$urandom, $urandom, $urandom, $urandom, $urandom};
    drive_vec(32'h300, 5'b00000, lanes, -1, "zero_mask");

    lanes = {$urandom, $urandom, $urandom, $urandom, $urandom};
    drive_vec(32'h400, 5'b11111, lanes, 2, "reset_mid");
    drive_scalar(1'b1, 32'h80, 32'hCAFE_F00D, "scalar_after_reset");

    lanes = {$urandom, $urandom, $urandom, $urandom, $urandom};
    drive_vec(32'h500, 5'b11011, lanes, -1, "b2b_first");
    lanes = {$urandom, $urandom, $urandom, $urandom, $urandom};
    drive_vec(32'h600, 5'b01110, lanes, -1, "b2b_second");

    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      lanes = {$urandom, $urandom, $urandom, $urandom, $urandom};
      if (r < 4) begin
        drive_scalar(1'($urandom), $urandom, $urandom, $sformatf("rnd%0d_scalar", n));
      end else if (r == 9) begin
        drive_vec($urandom, 5'($urandom), lanes, $urandom_range(0, 4), $sformatf("rnd%0d_abort", n));
      end else begin
        drive_vec($urandom, 5'($urandom), lanes, -1, $sformatf("rnd%0d_vec", n));
      end
    end

    drive_scalar(1'b0, 32'h0, 32'h0, "final_idle");
    @(posedge clk);
    @(negedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
